// File: rtl/i2c_multi_periph.sv
// Oversampled I2C target answering NUM_DEV consecutive 7-bit addresses, each backed by a DEPTH-byte bank.
// Writes set a per-device register pointer and then stream auto-incrementing data; reads stream from that pointer.
module i2c_multi_periph #(
  parameter logic [6:0] BASE_ADDR   = 7'h2A,
  parameter int         NUM_DEV     = 2,
  parameter int         DEPTH       = 16,
  parameter int         SYNC_STAGES = 2,
  localparam int        PTR_W       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             scl_in,
  input  logic             sda_in,
  output logic             sda_oe,
  output logic             busy,
  output logic             wr_valid,
  output logic [2:0]       wr_dev,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [7:0]       wr_data,
  input  logic [2:0]       host_dev,
  input  logic [PTR_W-1:0] host_ptr,
  output logic [7:0]       host_rdata,
  output logic [3:0]       state_dbg
);
  localparam int         DEV_IW = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;
  localparam int         DEVS   = 1 << DEV_IW;
  localparam logic [7:0] BASE8  = {1'b0, BASE_ADDR};
  localparam logic [7:0] NDEV8  = 8'(NUM_DEV);
  localparam logic [3:0] NDEV4  = 4'(NUM_DEV);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_PTR, S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK, S_IGNORE
  } state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_prev_q, sda_prev_q;
  logic [3:0]             cnt_q, cnt_d;
  logic [7:0]             sh_q, sh_d, tx_q, tx_d;
  logic [DEV_IW-1:0]      dev_q, dev_d;
  logic                   rw_q, rw_d, ack_q, ack_d;
  logic                   sda_oe_q, sda_oe_d, busy_q, busy_d;
  logic                   wr_valid_q;
  logic [2:0]             wr_dev_q;
  logic [PTR_W-1:0]       wr_ptr_q;
  logic [7:0]             wr_data_q, host_rdata_q;
  logic [PTR_W-1:0]       ptr_q [DEVS];
  logic [7:0]             mem_q [DEVS][DEPTH];

  logic             scl_s, sda_s, scl_rise, scl_fall, start_ev, stop_ev;
  logic [7:0]       sh_next, addr_off;
  logic             addr_hit, byte_done, ptr_load, data_wr, rd_done, host_ok;
  logic [PTR_W-1:0] cur_ptr;

  assign scl_s    = scl_sync_q[SYNC_STAGES-1];
  assign sda_s    = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_prev_q;
  assign scl_fall = ~scl_s & scl_prev_q;
  assign start_ev = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_ev  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

  assign sh_next   = {sh_q[6:0], sda_s};
  assign addr_off  = {1'b0, sh_q[7:1]} - BASE8;
  assign addr_hit  = ({1'b0, sh_q[7:1]} >= BASE8) && (addr_off < NDEV8);
  assign byte_done = scl_rise && (cnt_q == 4'd7);
  assign cur_ptr   = ptr_q[dev_q];
  assign ptr_load  = (state_q == S_WR_PTR) && byte_done;
  assign data_wr   = (state_q == S_WR_DATA) && byte_done;
  assign rd_done   = (state_q == S_RD_DATA) && scl_fall && (cnt_q == 4'd8);
  assign host_ok   = ({1'b0, host_dev} < NDEV4);

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // START/STOP override everything; every other move happens on an SCL fall so SDA only changes while SCL is low.
  always_comb begin
    state_d = state_q;
    if (start_ev) begin
      state_d = S_ADDR;
    end else if (stop_ev) begin
      state_d = S_IDLE;
    end else if (scl_fall) begin
      case (state_q)
        S_ADDR:              if (cnt_q == 4'd8) state_d = addr_hit ? S_ADDR_ACK : S_IGNORE;
        S_ADDR_ACK:          state_d = rw_q ? S_RD_DATA : S_WR_PTR;
        S_WR_PTR, S_WR_DATA: if (cnt_q == 4'd8) state_d = S_WR_ACK;
        S_WR_ACK:            state_d = S_WR_DATA;
        S_RD_DATA:           if (cnt_q == 4'd8) state_d = S_RD_ACK;
        S_RD_ACK:            state_d = ack_q ? S_IGNORE : S_RD_DATA;
        default:             state_d = state_q;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    sh_d  = sh_q;
    tx_d  = tx_q;
    dev_d = dev_q;
    rw_d  = rw_q;
    ack_d = ack_q;
    if (start_ev || (state_d != state_q)) cnt_d = '0;
    else if (scl_rise && (cnt_q != 4'd8)) cnt_d = cnt_q + 4'd1;
    if (scl_rise) sh_d = sh_next;
    if ((state_q == S_ADDR) && scl_fall && (cnt_q == 4'd8) && addr_hit) begin
      dev_d = addr_off[DEV_IW-1:0];
      rw_d  = sh_q[0];
    end
    if ((state_d == S_RD_DATA) && (state_q != S_RD_DATA)) tx_d = mem_q[dev_q][cur_ptr];
    else if ((state_q == S_RD_DATA) && scl_fall && (cnt_q != 4'd8)) tx_d = {tx_q[6:0], 1'b1};
    if ((state_q == S_RD_ACK) && scl_rise) ack_d = sda_s;
  end

  // Pad outputs are decoded from the next state so they register alongside the state itself.
  always_comb begin
    case (state_d)
      S_ADDR_ACK, S_WR_ACK: sda_oe_d = 1'b1;
      S_RD_DATA:            sda_oe_d = ~tx_d[7];
      default:              sda_oe_d = 1'b0;
    endcase
    busy_d = busy_q;
    if (start_ev || stop_ev)       busy_d = 1'b0;
    else if (state_d == S_ADDR_ACK) busy_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sync_q   <= '1;
      sda_sync_q   <= '1;
      scl_prev_q   <= 1'b1;
      sda_prev_q   <= 1'b1;
      cnt_q        <= '0;
      sh_q         <= '0;
      tx_q         <= '0;
      dev_q        <= '0;
      rw_q         <= 1'b0;
      ack_q        <= 1'b1;
      sda_oe_q     <= 1'b0;
      busy_q       <= 1'b0;
      wr_valid_q   <= 1'b0;
      wr_dev_q     <= '0;
      wr_ptr_q     <= '0;
      wr_data_q    <= '0;
      host_rdata_q <= '0;
      for (int d = 0; d < DEVS; d++) begin
        ptr_q[d] <= '0;
        for (int i = 0; i < DEPTH; i++) mem_q[d][i] <= '0;
      end
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      tx_q       <= tx_d;
      dev_q      <= dev_d;
      rw_q       <= rw_d;
      ack_q      <= ack_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      if (ptr_load)               ptr_q[dev_q] <= sh_next[PTR_W-1:0];
      else if (data_wr || rd_done) ptr_q[dev_q] <= cur_ptr + 1'b1;
      if (data_wr) mem_q[dev_q][cur_ptr] <= sh_next;
      // wr_valid is a one-cycle strobe with no back-pressure; wr_dev/wr_ptr/wr_data hold between strobes.
      wr_valid_q <= data_wr;
      if (data_wr) begin
        wr_dev_q  <= 3'(dev_q);
        wr_ptr_q  <= cur_ptr;
        wr_data_q <= sh_next;
      end
      host_rdata_q <= host_ok ? mem_q[host_dev[DEV_IW-1:0]][host_ptr] : 8'h00;
    end
  end

  assign sda_oe     = sda_oe_q;
  assign busy       = busy_q;
  assign wr_valid   = wr_valid_q;
  assign wr_dev     = wr_dev_q;
  assign wr_ptr     = wr_ptr_q;
  assign wr_data    = wr_data_q;
  assign host_rdata = host_rdata_q;
  assign state_dbg  = state_q;
endmodule

// File: tb/tb_i2c_multi_periph.sv
// Directed bench for i2c_multi_periph: a bit-banged I2C master, a write-event scoreboard and host-port checks.
module tb_i2c_multi_periph;
  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic [2:0] host_dev = 3'd0;
  logic [3:0] host_ptr = 4'd0;
  logic       sda_oe, busy, wr_valid;
  logic [2:0] wr_dev;
  logic [3:0] wr_ptr;
  logic [7:0] wr_data, host_rdata;
  logic [3:0] state_dbg;
  logic       sda_line;

  assign sda_line = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_multi_periph dut (
    .clk(clk), .reset(reset), .scl_in(scl_m), .sda_in(sda_line),
    .sda_oe(sda_oe), .busy(busy), .wr_valid(wr_valid),
    .wr_dev(wr_dev), .wr_ptr(wr_ptr), .wr_data(wr_data),
    .host_dev(host_dev), .host_ptr(host_ptr), .host_rdata(host_rdata),
    .state_dbg(state_dbg)
  );

  logic [14:0] exp_q[$];
  logic [14:0] mon_exp;
  int          total = 0;
  int          bad = 0;
  int          quiet_hits = 0;
  logic        quiet = 1'b0;

  // Write-event monitor: every wr_valid strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (!reset && wr_valid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL wr_unexpected got=%h want=none", {wr_dev, wr_ptr, wr_data});
      end else begin
        mon_exp = exp_q.pop_front();
        if ({wr_dev, wr_ptr, wr_data} !== mon_exp) begin
          bad++;
          $display("FAIL wr_event got=%h want=%h", {wr_dev, wr_ptr, wr_data}, mon_exp);
        end
      end
    end
  end

  always @(negedge clk) if (quiet && sda_oe) quiet_hits++;

  initial begin
    repeat (90000) @(posedge clk);
    bad++;
    $display("FAIL watchdog got=timeout want=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_q();
    scl_m = 1'b1; wait_q();
    sda_m = 1'b1; wait_q();
  endtask

  task automatic clock_bit(input logic b, output logic r);
    sda_m = b;    wait_q();
    scl_m = 1'b1; wait_q();
    r = sda_line; wait_q();
    scl_m = 1'b0; wait_q();
  endtask

  task automatic write_byte(input logic [7:0] v, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) clock_bit(v[i], r);
    clock_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] v);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, r);
      v[i] = r;
    end
    clock_bit(nack, r);
  endtask

  task automatic send(input logic [7:0] v, input string name);
    logic a;
    write_byte(v, a);
    check(name, 32'(a), 32'd0);
  endtask

  task automatic recv(input logic nack, input logic [7:0] want, input string name);
    logic [7:0] v;
    read_byte(nack, v);
    check(name, 32'(v), 32'(want));
  endtask

  task automatic push_wr(input logic [2:0] d, input logic [3:0] p, input logic [7:0] v);
    exp_q.push_back({d, p, v});
  endtask

  task automatic host_read(input logic [2:0] d, input logic [3:0] p, input logic [7:0] want, input string name);
    @(negedge clk);
    host_dev = d;
    host_ptr = p;
    @(negedge clk);
    check(name, 32'(host_rdata), 32'(want));
  endtask

  initial begin
    logic       a, r;
    logic [8:0] tail;

    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_sda_oe", 32'(sda_oe), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wr_valid", 32'(wr_valid), 32'd0);
    check("rst_wr_fields", 32'({wr_dev, wr_ptr, wr_data}), 32'd0);
    check("rst_host_rdata", 32'(host_rdata), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);

    // Plain write: pointer 3, two data bytes.
    i2c_start();
    send(8'h54, "t1_addr_ack");
    check("t1_busy", 32'(busy), 32'd1);
    send(8'h03, "t1_ptr_ack");
    push_wr(3'd0, 4'd3, 8'hA5);
    send(8'hA5, "t1_d0_ack");
    push_wr(3'd0, 4'd4, 8'h5A);
    send(8'h5A, "t1_d1_ack");
    i2c_stop();
    check("t1_busy_after_stop", 32'(busy), 32'd0);
    check("t1_wr_hold", 32'({wr_dev, wr_ptr, wr_data}), 32'({3'd0, 4'd4, 8'h5A}));
    host_read(3'd0, 4'd4, 8'h5A, "t1_host_p4");

    // Pointer wrap on dev1, then repeated-START reads.
    i2c_start();
    send(8'h56, "t2_addr_ack");
    send(8'h0F, "t2_ptr_ack");
    push_wr(3'd1, 4'd15, 8'h11);
    send(8'h11, "t2_d0_ack");
    push_wr(3'd1, 4'd0, 8'h22);
    send(8'h22, "t2_d1_ack");
    i2c_start();
    send(8'h57, "t2_rd_addr_ack");
    recv(1'b0, 8'h00, "t2_rd0");
    recv(1'b1, 8'h00, "t2_rd1");
    i2c_stop();
    i2c_start();
    send(8'h56, "t2b_addr_ack");
    send(8'h0F, "t2b_ptr_ack");
    i2c_start();
    send(8'h57, "t2b_rd_addr_ack");
    recv(1'b0, 8'h11, "t2b_rd0");
    recv(1'b1, 8'h22, "t2b_rd1");
    i2c_stop();
    host_read(3'd1, 4'd0, 8'h22, "t2_host_b1p0");
    host_read(3'd1, 4'd15, 8'h11, "t2_host_b1p15");
    host_read(3'd0, 4'd3, 8'hA5, "t2_host_b0p3");

    // Foreign address: never driven, never busy.
    quiet_hits = 0;
    quiet = 1'b1;
    i2c_start();
    write_byte(8'h60, a);
    check("t3_addr_nack", 32'(a), 32'd1);
    write_byte(8'h01, a);
    check("t3_b0_nack", 32'(a), 32'd1);
    write_byte(8'hFF, a);
    check("t3_b1_nack", 32'(a), 32'd1);
    check("t3_busy", 32'(busy), 32'd0);
    write_byte(8'h33, a);
    i2c_stop();
    quiet = 1'b0;
    check("t3_sda_quiet", 32'(quiet_hits), 32'd0);

    // Partial byte then STOP: pointer moved to 2, nothing written.
    i2c_start();
    send(8'h54, "t4_addr_ack");
    send(8'h02, "t4_ptr_ack");
    clock_bit(1'b1, r);
    clock_bit(1'b1, r);
    clock_bit(1'b0, r);
    clock_bit(1'b1, r);
    i2c_stop();
    host_read(3'd0, 4'd2, 8'h00, "t4_host_p2_untouched");
    i2c_start();
    send(8'h55, "t4_rd_addr_ack");
    recv(1'b1, 8'h00, "t4_rd_ptr_kept");
    i2c_stop();
    i2c_start();
    send(8'h54, "t4b_addr_ack");
    send(8'h02, "t4b_ptr_ack");
    push_wr(3'd0, 4'd2, 8'h77);
    send(8'h77, "t4b_d0_ack");
    i2c_stop();
    host_read(3'd0, 4'd2, 8'h77, "t4_host_p2");

    // Reset in the middle of a read byte (dev0 pointer now 3 -> 0xA5, bit6 is 0).
    i2c_start();
    send(8'h55, "t5_addr_ack");
    clock_bit(1'b1, r);
    check("t5_bit7", 32'(r), 32'd1);
    check("t5_driving_bit6", 32'(sda_oe), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("t5_rst_sda_oe", 32'(sda_oe), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_state", 32'(state_dbg), 32'd0);
    reset = 1'b0;
    host_read(3'd0, 4'd2, 8'h00, "t5_host_b0p2_cleared");
    host_read(3'd1, 4'd15, 8'h00, "t5_host_b1p15_cleared");
    i2c_start();
    send(8'h56, "t5_addr2_ack");
    send(8'h05, "t5_ptr_ack");
    push_wr(3'd1, 4'd5, 8'h3C);
    send(8'h3C, "t5_d0_ack");
    push_wr(3'd1, 4'd6, 8'h81);
    send(8'h81, "t5_d1_ack");
    i2c_stop();
    host_read(3'd1, 4'd5, 8'h3C, "t5_host_b1p5");

    // Master NACK: SDA released for the rest of the transaction.
    i2c_start();
    send(8'h56, "t6_addr_ack");
    send(8'h06, "t6_ptr_ack");
    i2c_start();
    send(8'h57, "t6_rd_addr_ack");
    recv(1'b1, 8'h81, "t6_rd0");
    quiet_hits = 0;
    quiet = 1'b1;
    for (int i = 8; i >= 0; i--) begin
      clock_bit(1'b1, r);
      tail[i] = r;
    end
    check("t6_tail_released", 32'(tail), 32'h1FF);
    i2c_stop();
    quiet = 1'b0;
    check("t6_sda_quiet", 32'(quiet_hits), 32'd0);

    wait_q();
    check("wr_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
